lap_memory_ctrl: RTL and testbench
==================================

Name: lap_memory_ctrl

Overview:
Controller sequencing the stopwatch's 16 x 24-bit lap-time register file. Captures the running time on a lap request and issues a single-cycle write (strobe, address, data). Tracks the number of stored laps and drives the read address for browsing stored laps on the display. Sits between the debounced button logic / time counter and the register file.

Parameters:
DATA_W, 24, width of one time word (6 BCD digits)
ADDR_W, 4, register-file address width
DEPTH, 16, number of lap slots; must equal 2**ADDR_W

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
time_in  input  DATA_W  live stopwatch time
lap  input  1  one-cycle lap request pulse
clear  input  1  one-cycle clear-all pulse
next  input  1  one-cycle browse-forward pulse
prev  input  1  one-cycle browse-backward pulse
wr_en  output  1  write strobe to register file, one cycle per stored lap
wr_addr  output  ADDR_W  write slot
wr_data  output  DATA_W  captured lap time
rd_addr  output  ADDR_W  slot selected for display
lap_count  output  ADDR_W+1  stored laps, 0..DEPTH
empty  output  1  lap_count == 0
full  output  1  lap_count == DEPTH
lap_dropped  output  1  one-cycle pulse when a lap is refused because full

Behaviour:
- Clock and reset: one clock (clk); reset asynchronous, active-high.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, rd_addr=0, lap_count=0, empty=1, full=0, lap_dropped=0, FSM=IDLE, pending=0.
- FSM states: IDLE, WRITE, UPDATE.
- IDLE:
  - lap (or pending) and !full: register time_in into wr_data, wr_addr=lap_count[ADDR_W-1:0], go to WRITE.
  - lap and full: pulse lap_dropped next cycle; stay in IDLE.
- WRITE: wr_en=1 for exactly this cycle; wr_data and wr_addr are stable. Go to UPDATE.
- UPDATE:
  - lap_count+=1.
  - rd_addr=wr_addr, so the newest lap is auto-displayed.
  - Return to IDLE.
- Latency: lap at cycle N -> wr_en high in cycle N+1 -> lap_count/rd_addr updated and visible in cycle N+2. Minimum spacing between accepted laps is 3 cycles.
- Lap during WRITE/UPDATE: set a one-deep pending flag, serviced from IDLE next. A further lap while pending=1 is lost and does not pulse lap_dropped.
- Browse (IDLE only, count>0):
  - next: rd_addr+1, saturates at lap_count-1.
  - prev: rd_addr-1, saturates at 0.
  - next and prev together: no change.
  - Ignored when empty, and ignored outside IDLE.
- clear has top priority in any state:
  - Next edge: lap_count=0, rd_addr=0, wr_addr=0, pending=0, FSM=IDLE, wr_en=0.
  - A write in progress is aborted; the slot content is don't-care.
- Priority within a cycle: clear > lap > next/prev.
- full/empty are combinational decodes of lap_count. No wrap-around: a full memory refuses laps until cleared.
- wr_en is never asserted when full=1, and never for two consecutive cycles.
- The register file's write clock is driven as clk gated by wr_en externally. wr_data/wr_addr are held stable across the wr_en cycle.

Decomposition:
- Shared package: DATA_W, ADDR_W and DEPTH defaults; FSM state encoding (IDLE=2'd0, WRITE=2'd1, UPDATE=2'd2).
- One natural sub-module: lap_browse_ptr. It holds the saturating rd_addr up/down counter bounded by lap_count, with load (from UPDATE) and clear inputs.

Test Plan:
- Reset mid-operation: assert reset during WRITE -> all outputs return to reset values immediately (asynchronously); wr_en=0.
- Single lap: time_in=24'h012345, lap at cycle 10 -> wr_en=1 in cycle 11 with wr_addr=0, wr_data=24'h012345; cycle 12 lap_count=1, rd_addr=0, empty=0.
- Fill and overflow: 16 laps spaced 3 cycles with time_in=i -> wr_addr 0..15, full=1 after the 16th; 17th lap -> lap_dropped pulse, no wr_en, lap_count stays 16.
- Back-to-back laps: lap pulses at cycles 0 and 1 -> two writes to addr 0 and 1 (wr_en cycles 1 and 4), lap_count=2; a third pulse at cycle 2 is lost.
- Browse: with 3 laps (rd_addr=2), two prevs -> 1, 0; third prev -> 0; next x4 -> 1, 2, 2, 2; next with empty memory -> rd_addr stays 0.
- Clear priority: clear and lap in the same cycle with lap_count=5 -> next cycle lap_count=0, rd_addr=0, no wr_en.

Source files
------------

// File: rtl/lap_memory_ctrl_pkg.sv
// Shared sizing defaults and FSM encoding for the stopwatch lap-memory controller.
package lap_memory_ctrl_pkg;

    localparam int LAP_DATA_W = 24;
    localparam int LAP_ADDR_W = 4;
    localparam int LAP_DEPTH  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        UPDATE = 2'd2
    } lap_state_t;

endpackage

// File: rtl/lap_browse_ptr.sv
// Display read pointer: loadable, clearable, saturating up/down counter
// bounded to the stored laps.
module lap_browse_ptr
    import lap_memory_ctrl_pkg::*;
#(
    parameter int ADDR_W = LAP_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              en,
    input  logic              next,
    input  logic              prev,
    input  logic [ADDR_W:0]   lap_count,
    output logic [ADDR_W-1:0] rd_addr
);

    logic [ADDR_W:0] rd_inc;
    logic            can_inc;
    logic            can_dec;
    logic            have_laps;

    assign rd_inc    = (ADDR_W+1)'(rd_addr) + 1'b1;
    assign have_laps = (lap_count != '0);
    assign can_inc   = (rd_inc < lap_count);
    assign can_dec   = (rd_addr != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_addr <= '0;
        end else if (clear) begin
            rd_addr <= '0;
        end else if (load) begin
            rd_addr <= load_addr;
        end else if (en && have_laps && (next ^ prev)) begin
            // Both directions at once cancel out; each saturates at its end.
            if (next && can_inc) begin
                rd_addr <= rd_inc[ADDR_W-1:0];
            end else if (prev && can_dec) begin
                rd_addr <= rd_addr - 1'b1;
            end
        end
    end

endmodule

// File: rtl/lap_memory_ctrl.sv
// Lap capture sequencer: latches the running time on a lap request, issues one
// write strobe to the lap register file and tracks count / browse pointer.
module lap_memory_ctrl
    import lap_memory_ctrl_pkg::*;
#(
    parameter int DATA_W = LAP_DATA_W,
    parameter int ADDR_W = LAP_ADDR_W,
    parameter int DEPTH  = LAP_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] time_in,
    input  logic              lap,
    input  logic              clear,
    input  logic              next,
    input  logic              prev,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W:0]   lap_count,
    output logic              empty,
    output logic              full,
    output logic              lap_dropped
);

    lap_state_t        state_q;
    lap_state_t        state_d;
    logic              pending_q;
    logic              pending_d;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              dropped_q;
    logic              accept;
    logic              drop;
    logic              browse_en;
    logic              load_ptr;

    assign full      = (count_q == (ADDR_W+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign wr_en     = (state_q == WRITE);
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign lap_count = count_q;
    assign lap_dropped = dropped_q;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        accept    = 1'b0;
        drop      = 1'b0;
        browse_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (lap || pending_q) begin
                    // A fresh lap arriving alongside a pending one is lost.
                    pending_d = 1'b0;
                    if (!full) begin
                        accept  = 1'b1;
                        state_d = WRITE;
                    end else begin
                        drop = 1'b1;
                    end
                end else begin
                    browse_en = 1'b1;
                end
            end
            WRITE: begin
                if (lap) pending_d = 1'b1;
                state_d = UPDATE;
            end
            UPDATE: begin
                if (lap) pending_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                pending_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            count_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            dropped_q <= 1'b0;
        end else if (clear) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            count_q   <= '0;
            wr_addr_q <= '0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            dropped_q <= drop;
            if (accept) begin
                wr_data_q <= time_in;
                wr_addr_q <= count_q[ADDR_W-1:0];
            end
            // Count lands as the strobe ends, visible during UPDATE.
            if (state_q == WRITE) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign load_ptr = (state_q == WRITE);

    lap_browse_ptr #(
        .ADDR_W (ADDR_W)
    ) u_browse (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .load      (load_ptr),
        .load_addr (wr_addr_q),
        .en        (browse_en),
        .next      (next),
        .prev      (prev),
        .lap_count (count_q),
        .rd_addr   (rd_addr)
    );

endmodule

// File: tb/tb_lap_memory_ctrl.sv
// Self-checking bench: directed lap/browse/clear sequences against a
// cycle-level lap model, plus literal expectations from the scenarios.
module tb_lap_memory_ctrl;

    logic        clk;
    logic        reset;
    logic [23:0] time_in;
    logic        lap;
    logic        clear;
    logic        next;
    logic        prev;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [23:0] wr_data;
    logic [3:0]  rd_addr;
    logic [4:0]  lap_count;
    logic        empty;
    logic        full;
    logic        lap_dropped;

    int n_cmp = 0;
    int n_bad = 0;

    lap_memory_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .time_in     (time_in),
        .lap         (lap),
        .clear       (clear),
        .next        (next),
        .prev        (prev),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr     (rd_addr),
        .lap_count   (lap_count),
        .empty       (empty),
        .full        (full),
        .lap_dropped (lap_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Model: stored laps, browse index, and phase since acceptance
    // (0 = ready, 1 = strobe cycle, 2 = settle cycle).
    int          m_cnt;
    int          m_rd;
    int          m_wa;
    logic [23:0] m_wd;
    int          m_ph;
    bit          m_pend;
    bit          m_drop;

    always @(posedge clk or posedge reset) begin : model
        int          c, r, wa, ph;
        logic [23:0] wd;
        bit          p, d;
        if (reset) begin
            m_cnt <= 0; m_rd <= 0; m_wa <= 0; m_wd <= '0;
            m_ph <= 0; m_pend <= 0; m_drop <= 0;
        end else begin
            c = m_cnt; r = m_rd; wa = m_wa; wd = m_wd;
            ph = m_ph; p = m_pend; d = 0;
            if (clear) begin
                c = 0; r = 0; wa = 0; ph = 0; p = 0;
            end else if (ph == 0) begin
                if (lap || p) begin
                    if (c < 16) begin
                        wa = c; wd = time_in; ph = 1;
                    end else begin
                        d = 1;
                    end
                    p = 0;
                end else if (c > 0 && next && !prev) begin
                    r = (r + 1 < c) ? r + 1 : c - 1;
                end else if (c > 0 && prev && !next) begin
                    r = (r > 0) ? r - 1 : 0;
                end
            end else begin
                if (lap) p = 1;
                if (ph == 1) begin
                    c = c + 1; r = wa; ph = 2;
                end else begin
                    ph = 0;
                end
            end
            m_cnt <= c; m_rd <= r; m_wa <= wa; m_wd <= wd;
            m_ph <= ph; m_pend <= p; m_drop <= d;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("wr_en", 32'(wr_en), 32'(m_ph == 1));
            check("wr_addr", 32'(wr_addr), 32'(m_wa));
            check("wr_data", 32'(wr_data), 32'(m_wd));
            check("rd_addr", 32'(rd_addr), 32'(m_rd));
            check("lap_count", 32'(lap_count), 32'(m_cnt));
            check("empty", 32'(empty), 32'(m_cnt == 0));
            check("full", 32'(full), 32'(m_cnt == 16));
            check("lap_dropped", 32'(lap_dropped), 32'(m_drop));
            check("no_wr_when_full", 32'(wr_en && full), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_lap(input logic [23:0] t);
        time_in = t;
        lap = 1'b1;
        tick();
        lap = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic pulse_nav(input bit n, input bit p);
        next = n;
        prev = p;
        tick();
        next = 1'b0;
        prev = 1'b0;
    endtask

    logic [6:0] wr_hist;

    initial begin
        reset = 1'b1;
        time_in = '0;
        lap = 0; clear = 0; next = 0; prev = 0;
        tick(); tick(); tick();
        reset = 1'b0;
        tick();
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_count", 32'(lap_count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_rd", 32'(rd_addr), 32'd0);

        // Single lap timing.
        time_in = 24'h012345;
        lap = 1'b1;
        tick();
        lap = 1'b0;
        time_in = 24'h999999;
        check("single_wr_en", 32'(wr_en), 32'd1);
        check("single_wr_addr", 32'(wr_addr), 32'd0);
        check("single_wr_data", 32'(wr_data), 32'h012345);
        tick();
        check("single_wr_en_off", 32'(wr_en), 32'd0);
        check("single_count", 32'(lap_count), 32'd1);
        check("single_rd", 32'(rd_addr), 32'd0);
        check("single_empty", 32'(empty), 32'd0);
        tick();

        // Browse over three laps.
        do_lap(24'h000111);
        do_lap(24'h000222);
        check("br_count", 32'(lap_count), 32'd3);
        check("br_rd_newest", 32'(rd_addr), 32'd2);
        pulse_nav(0, 1); check("br_prev1", 32'(rd_addr), 32'd1);
        pulse_nav(0, 1); check("br_prev2", 32'(rd_addr), 32'd0);
        pulse_nav(0, 1); check("br_prev3", 32'(rd_addr), 32'd0);
        pulse_nav(1, 0); check("br_next1", 32'(rd_addr), 32'd1);
        pulse_nav(1, 1); check("br_both", 32'(rd_addr), 32'd1);
        pulse_nav(1, 0); check("br_next2", 32'(rd_addr), 32'd2);
        pulse_nav(1, 0); check("br_next3", 32'(rd_addr), 32'd2);
        pulse_nav(1, 0); check("br_next4", 32'(rd_addr), 32'd2);
        do_clear();
        check("clr_count", 32'(lap_count), 32'd0);
        pulse_nav(1, 0); check("br_next_empty", 32'(rd_addr), 32'd0);

        // Three consecutive lap pulses: third is lost.
        time_in = 24'h00AAAA;
        wr_hist = '0;
        for (int i = 0; i < 7; i++) begin
            lap = (i < 3);
            #3;
            wr_hist[i] = wr_en;
            tick();
        end
        lap = 1'b0;
        check("b2b_wr_pattern", 32'(wr_hist), 32'b0010010);
        check("b2b_count", 32'(lap_count), 32'd2);
        check("b2b_rd", 32'(rd_addr), 32'd1);
        tick();

        // Clear beats lap.
        do_lap(24'h000003);
        do_lap(24'h000004);
        do_lap(24'h000005);
        check("cp_count5", 32'(lap_count), 32'd5);
        clear = 1'b1;
        lap = 1'b1;
        tick();
        clear = 1'b0;
        lap = 1'b0;
        check("cp_count", 32'(lap_count), 32'd0);
        check("cp_rd", 32'(rd_addr), 32'd0);
        check("cp_wr_en", 32'(wr_en), 32'd0);
        tick();
        check("cp_wr_en2", 32'(wr_en), 32'd0);

        // Fill to capacity, then overflow.
        for (int i = 0; i < 16; i++) begin
            do_lap(24'(i));
        end
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(lap_count), 32'd16);
        check("fill_rd", 32'(rd_addr), 32'd15);
        check("fill_wr_addr", 32'(wr_addr), 32'd15);
        time_in = 24'h123456;
        lap = 1'b1;
        tick();
        lap = 1'b0;
        check("ovf_dropped", 32'(lap_dropped), 32'd1);
        check("ovf_wr_en", 32'(wr_en), 32'd0);
        tick();
        check("ovf_dropped_off", 32'(lap_dropped), 32'd0);
        check("ovf_count", 32'(lap_count), 32'd16);

        // Asynchronous reset in the middle of a write.
        do_clear();
        tick();
        time_in = 24'h000ABC;
        lap = 1'b1;
        tick();
        lap = 1'b0;
        check("ar_wr_en_before", 32'(wr_en), 32'd1);
        reset = 1'b1;
        #1;
        check("ar_wr_en", 32'(wr_en), 32'd0);
        check("ar_wr_addr", 32'(wr_addr), 32'd0);
        check("ar_wr_data", 32'(wr_data), 32'd0);
        check("ar_count", 32'(lap_count), 32'd0);
        check("ar_empty", 32'(empty), 32'd1);
        check("ar_rd", 32'(rd_addr), 32'd0);
        tick();
        reset = 1'b0;
        tick(); tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
